// File: rtl/sort_pkg.sv
// Shared definitions for the sorter, the loader and the result streamer.
package sort_pkg;
    localparam int LOG_INPUT  = 5;
    localparam int DATA_WIDTH = 8;
    localparam int N          = 2**LOG_INPUT;
    localparam int ELEM_MAX   = 32;
    localparam int VEC_MAX    = ELEM_MAX * N;

    typedef enum logic {IDLE, STREAM} rd_state_e;

    // Returns element idx of a dw-bit-per-element vector; caller truncates to dw.
    function automatic logic [ELEM_MAX-1:0] get_elem(input logic [VEC_MAX-1:0] vec,
                                                     input int idx, input int dw);
        return ELEM_MAX'(vec >> (idx * dw));
    endfunction
endpackage

// File: rtl/vector_slot_buffer.sv
// Two-slot ping-pong vector store with full bits and write/read pointers.
module vector_slot_buffer #(
    parameter int VW = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cap_i,
    input  logic [VW-1:0] cap_data_i,
    input  logic          free_i,
    output logic          cap_ok_o,
    output logic [VW-1:0] rd_data_o,
    output logic          rd_full_o,
    output logic          oth_full_o,
    output logic          busy_o
);
    logic [1:0][VW-1:0] slot_q;
    logic [1:0]         full_q, full_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;

    // Occupancy is judged on start-of-cycle state, so a slot freed now is not writable until next cycle.
    assign cap_ok_o   = cap_i & ~full_q[wr_ptr_q];
    assign rd_data_o  = slot_q[rd_ptr_q];
    assign rd_full_o  = full_q[rd_ptr_q];
    assign oth_full_o = full_q[~rd_ptr_q];
    assign busy_o     = |full_q;

    always_comb begin
        full_d   = full_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (cap_ok_o) begin
            full_d[wr_ptr_q] = 1'b1;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (free_i) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= '0;
            full_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (cap_ok_o) slot_q[wr_ptr_q] <= cap_data_i;
        end
    end
endmodule

// File: rtl/sorted_vector_streamer.sv
// Captures sorted vectors from the sorter and streams their elements one per beat.
module sorted_vector_streamer
    import sort_pkg::*;
#(
    parameter int LOG_INPUT  = sort_pkg::LOG_INPUT,
    parameter int DATA_WIDTH = sort_pkg::DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              y_valid,
    input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0] y,
    output logic [DATA_WIDTH-1:0]             m_data,
    output logic                              m_valid,
    input  logic                              m_ready,
    output logic [LOG_INPUT-1:0]              m_index,
    output logic                              m_last,
    output logic                              overflow,
    output logic                              busy
);
    localparam int NE = 2**LOG_INPUT;
    localparam int VW = DATA_WIDTH * NE;

    logic          cap_ok, rd_full, oth_full, hs, last, free;
    logic [VW-1:0] rd_data;
    rd_state_e     state_q, state_d;
    logic [LOG_INPUT-1:0] cnt_q, cnt_d;
    logic          ovf_q;

    vector_slot_buffer #(.VW(VW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .cap_i     (y_valid),
        .cap_data_i(y),
        .free_i    (free),
        .cap_ok_o  (cap_ok),
        .rd_data_o (rd_data),
        .rd_full_o (rd_full),
        .oth_full_o(oth_full),
        .busy_o    (busy)
    );

    assign last = (cnt_q == LOG_INPUT'(NE - 1));
    assign hs   = (state_q == STREAM) && m_ready;
    assign free = hs && last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            // Both slots are empty in IDLE, so any capture lands in the drain slot.
            IDLE: if (rd_full || cap_ok) state_d = STREAM;
            STREAM: begin
                if (hs) begin
                    cnt_d = cnt_q + LOG_INPUT'(1);
                    if (last) state_d = (oth_full || cap_ok) ? STREAM : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_q | (y_valid & ~cap_ok);
        end
    end

    assign m_valid  = (state_q == STREAM);
    assign m_data   = m_valid ? DATA_WIDTH'(get_elem(VEC_MAX'(rd_data), int'(cnt_q), DATA_WIDTH)) : '0;
    assign m_index  = cnt_q;
    assign m_last   = m_valid && last;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_sorted_vector_streamer.sv
// Directed and randomized checks of the streamer against a queue-based model.
module tb_sorted_vector_streamer;
    localparam int LI = 2;
    localparam int DW = 8;
    localparam int N  = 2**LI;

    logic          clk = 1'b0;
    logic          rst, y_valid, m_ready;
    logic [DW*N-1:0] y;
    logic [DW-1:0] m_data;
    logic          m_valid, m_last, overflow, busy;
    logic [LI-1:0] m_index;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mq[$];
    int          midx = 0;
    bit          movf = 1'b0;

    sorted_vector_streamer #(.LOG_INPUT(LI), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .y_valid(y_valid), .y(y),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_index(m_index), .m_last(m_last), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        bit v;
        v = (mq.size() > 0);
        chk("m_valid", 32'(m_valid), 32'(v));
        chk("busy", 32'(busy), 32'(v));
        chk("overflow", 32'(overflow), 32'(movf));
        if (v) begin
            chk("m_data", 32'(m_data), (mq[0] >> (midx * DW)) & 32'hff);
            chk("m_index", 32'(m_index), 32'(midx));
            chk("m_last", 32'(m_last), 32'(midx == N - 1));
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then compare.
    task automatic step(input bit r, input bit yv, input logic [31:0] yy, input bit rdy);
        int  occ;
        bit  hs;
        rst = r; y_valid = yv; y = yy; m_ready = rdy;
        @(posedge clk);
        if (r) begin
            mq.delete(); midx = 0; movf = 1'b0;
        end else begin
            occ = mq.size();
            hs  = (occ > 0) && rdy;
            if (yv) begin
                if (occ < 2) mq.push_back(yy);
                else movf = 1'b1;
            end
            if (hs) begin
                if (midx == N - 1) begin
                    void'(mq.pop_front());
                    midx = 0;
                end else midx++;
            end
        end
        #1;
        check_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        rst = 1'b1; y_valid = 1'b0; y = '0; m_ready = 1'b0;
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("rst_m_data", 32'(m_data), 32'h0);
        chk("rst_m_index", 32'(m_index), 32'h0);
        chk("rst_m_last", 32'(m_last), 32'h0);

        // single vector, full rate
        idle(3, 1'b1);
        step(1'b0, 1'b1, 32'h40302010, 1'b1);
        chk("lat_first", 32'(m_data), 32'h10);
        idle(5, 1'b1);

        // backpressure
        step(1'b0, 1'b1, 32'h40302010, 1'b1);
        begin
            bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
            foreach (pat[i]) step(1'b0, 1'b0, 32'h0, pat[i]);
        end
        idle(4, 1'b1);

        // back-to-back
        step(1'b0, 1'b1, 32'h04030201, 1'b1);
        idle(3, 1'b1);
        step(1'b0, 1'b1, 32'h08070605, 1'b1);
        idle(6, 1'b1);

        // overflow: two kept, third dropped
        step(1'b0, 1'b1, 32'h0d0c0b0a, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b1, 32'h1d1c1b1a, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 1'b1, 32'h2d2c2b2a, 1'b0);
        chk("ovf_set", 32'(overflow), 32'h1);
        idle(10, 1'b1);

        // simultaneous free and capture
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h33323130, 1'b0);
        step(1'b0, 1'b1, 32'h43424140, 1'b0);
        idle(3, 1'b1);
        step(1'b0, 1'b1, 32'h53525150, 1'b1);
        chk("simul_drop", 32'(overflow), 32'h1);
        step(1'b0, 1'b1, 32'h63626160, 1'b1);
        idle(10, 1'b1);

        // reset mid-stream
        step(1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h74737271, 1'b1);
        idle(2, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        chk("midrst_idx", 32'(m_index), 32'h0);
        step(1'b0, 1'b1, 32'h84838281, 1'b1);
        chk("fresh_first", 32'(m_data), 32'h81);
        idle(5, 1'b1);

        // randomized
        for (int ph = 0; ph < 4; ph++) begin
            int yprob;
            yprob = (ph == 0) ? 5 : (ph == 1) ? 20 : (ph == 2) ? 50 : 12;
            for (int c = 0; c < 1500; c++) begin
                bit r, yv, rdy;
                r   = ($urandom_range(499, 0) == 0);
                yv  = ($urandom_range(99, 0) < yprob);
                rdy = ($urandom_range(99, 0) < 75);
                step(r, yv, $urandom, rdy);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sorted_vector_streamer.md
Name: sorted_vector_streamer

Overview:
Consumer end of the sorter's parallel result interface. Captures each full sorted vector presented with y_valid and streams its elements out one per beat on a valid/ready interface, element 0 first. The sorter output has no backpressure, so the block holds two vector slots in a ping-pong arrangement. Overruns are reported through a sticky flag. It sits directly after the sort top, feeding serial downstream logic such as a DMA or UART packer.

Parameters:
LOG_INPUT, 5, log2 of elements per vector; N = 2**LOG_INPUT.
DATA_WIDTH, 8, bits per element.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
y_valid  input  1  one-cycle strobe from the sorter; y holds a complete sorted vector.
y  input  DATA_WIDTH*N  sorted vector; element i is bits [DATA_WIDTH*i +: DATA_WIDTH].
m_data  output  DATA_WIDTH  current element.
m_valid  output  1  m_data, m_index and m_last are valid.
m_ready  input  1  downstream accepts the beat when m_valid && m_ready.
m_index  output  LOG_INPUT  index of the current element within its vector.
m_last  output  1  high on element N-1 of a vector.
overflow  output  1  sticky; set when a vector is dropped, cleared only by rst.
busy  output  1  at least one slot is occupied.

Behaviour:
- Reset: all outputs are 0, both slots are empty, wr_ptr = rd_ptr = 0, element counter = 0. Reset mid-stream discards all buffered data. No beat completes in the reset cycle.
- Storage: two slots of DATA_WIDTH*N bits, each with a full bit.
  - wr_ptr selects the capture slot; rd_ptr selects the drain slot.
- Capture: on y_valid, if slot[wr_ptr] is empty at the start of the cycle, latch y into it, set its full bit and toggle wr_ptr.
  - If it is full, drop y, set overflow and leave wr_ptr unchanged.
  - Occupancy is evaluated before this cycle's drain. A slot freed by the final handshake in cycle t is writable from t+1 only, so y_valid in that same cycle is dropped.
- Read FSM, two states:
  - IDLE: m_valid = 0. Move to STREAM when slot[rd_ptr] is full.
  - STREAM: m_valid = 1.
    - m_data = slot[rd_ptr] element[cnt], m_index = cnt, m_last = (cnt == N-1).
    - On handshake with cnt < N-1: cnt increments.
    - On handshake with cnt == N-1: clear slot[rd_ptr].full, toggle rd_ptr, cnt = 0.
    - After the last beat, stay in STREAM if the other slot is full (zero-bubble back-to-back vectors); otherwise go to IDLE.
- Latency: y_valid in cycle t into an idle, empty block gives m_valid = 1 with element 0 in cycle t+1.
- Holding rules:
  - While m_valid && !m_ready, m_data, m_index and m_last stay stable.
  - m_valid never drops without a handshake.
- Path isolation:
  - All outputs depend only on registered state; there is no combinational path from m_ready or y_valid to any output.
  - m_data may be a mux of registered slot data selected by registered cnt and rd_ptr.
- cnt is LOG_INPUT bits wide and wraps naturally from N-1 to 0.
- busy = slot0.full | slot1.full.
- Sustained throughput is 1 element/cycle. Lossless operation requires y_valid spacing of at least N cycles under full m_ready.

Decomposition:
- Shared package sort_pkg holds:
  - localparam N = 2**LOG_INPUT;
  - the element-slice function get_elem(vec, idx);
  - the read-FSM state enum {IDLE, STREAM}.
  These are reused by the sorter and the loader.
- One natural sub-module: vector_slot_buffer. It holds the two-slot storage, the full bits, and the wr_ptr/rd_ptr logic, with capture/free inputs and a read-data output.
- The FSM and counter stay in the top.

Test Plan:
- LOG_INPUT=2, DATA_WIDTH=8, m_ready=1; y = {8'h40,8'h30,8'h20,8'h10}, y_valid at cycle 5 -> m_valid in cycles 6-9 with m_data 10,20,30,40; m_index 0..3; m_last only at cycle 9; busy falls at cycle 10.
- Backpressure: same vector, m_ready toggled 1,0,0,1,1,0,1 -> exactly 4 beats in order 10,20,30,40, with outputs held stable during stalls.
- Back-to-back: vectors A = {04,03,02,01} at cycle 0 and B = {08,07,06,05} at cycle 4, m_ready=1 -> 8 consecutive beats 01..08 with no bubble and m_last on 04 and 08.
- Overflow: m_ready=0, three y_valid strobes with vectors A, B, C -> A and B are kept and C is dropped; overflow = 1 from the cycle after C. Releasing m_ready then gives A then B, and overflow remains 1.
- Simultaneous free and capture: both slots full, a vector's final handshake and y_valid in the same cycle -> the new vector is dropped and overflow is set. The same y_valid one cycle later is accepted.
- Reset mid-stream: rst asserted after beat 2 of 4 -> the next cycle shows m_valid = 0, busy = 0, overflow = 0, m_index = 0. A fresh vector afterwards streams from element 0.
